// File: rtl/poci_master_if.sv
// rtl/poci_master_if.sv - POCI bus signal bundle with initiator and follower views
interface if_poci;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport initiator (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport follower (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/poci_master.sv
// rtl/poci_master.sv - single-outstanding POCI initiator with wait states and access timeout
module poci_master #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        pclk,
   input  logic        presetn,
   if_poci.initiator   bus,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Last ACCESS cycle index before abort; only meaningful when TIMEOUT != 0.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign req_ready = (state == IDLE);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state       <= IDLE;
         cnt         <= '0;
         bus.psel    <= 1'b0;
         bus.penable <= 1'b0;
         bus.pwrite  <= 1'b0;
         bus.paddr   <= '0;
         bus.pwdata  <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  bus.pwrite <= req_write;
                  bus.paddr  <= req_addr;
                  bus.pwdata <= req_wdata;
                  bus.psel   <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               bus.penable <= 1'b1;
               cnt         <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               // pready wins over the timeout in the last allowed cycle.
               if (bus.pready) begin
                  bus.psel    <= 1'b0;
                  bus.penable <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= bus.pwrite ? '0 : bus.prdata;
                  rsp_err     <= bus.pslverr;
                  rsp_timeout <= 1'b0;
                  state       <= IDLE;
               end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                  bus.psel    <= 1'b0;
                  bus.penable <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               bus.psel    <= 1'b0;
               bus.penable <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poci_master.sv
// tb/tb_poci_master.sv - directed self-checking bench for poci_master (TIMEOUT=4)
module tb_poci_master;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;

   logic        b2b_mode = 1'b0;
   logic [31:0] prdata_val = '0;
   int          checks = 0;
   int          failures = 0;

   if_poci bus_if ();

   always #5 pclk = ~pclk;

   // Follower read data: fixed value, or address-derived during back-to-back runs.
   always_comb begin
      bus_if.prdata = b2b_mode ? (bus_if.paddr ^ 32'hF0F0_0000) : prdata_val;
   end

   poci_master #(.TIMEOUT(4), .CNT_W(8)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .bus        (bus_if),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      bus_if.pready  = 1'b0;
      bus_if.pslverr = 1'b0;
      presetn = 1'b0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      checks++;
      if ({bus_if.psel, bus_if.penable, bus_if.pwrite} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=000", {bus_if.psel, bus_if.penable, bus_if.pwrite});
      end
      checks++;
      if ({bus_if.paddr, bus_if.pwdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_addr_data got=%h exp=0", {bus_if.paddr, bus_if.pwdata});
      end
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_timeout} !== 4'b1000 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rsp got=%b/%h exp=1000/0", {req_ready, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
      end
      tick();
      presetn = 1'b1;
      tick();
   endtask

   task automatic test_read_zero_wait();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      bus_if.pready = 1'b1; bus_if.pslverr = 1'b0; prdata_val = 32'h0000_0005;
      tick();
      req_valid = 1'b0;
      @(negedge pclk);
      checks++;
      if ({bus_if.psel, bus_if.penable, req_ready} !== 3'b100) begin
         failures++;
         $display("FAIL rd0_setup got=%b exp=100", {bus_if.psel, bus_if.penable, req_ready});
      end
      tick();
      @(negedge pclk);
      checks++;
      if ({bus_if.psel, bus_if.penable, rsp_valid} !== 3'b110) begin
         failures++;
         $display("FAIL rd0_access got=%b exp=110", {bus_if.psel, bus_if.penable, rsp_valid});
      end
      tick();
      @(negedge pclk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, bus_if.psel, req_ready} !== 5'b10001 || rsp_rdata !== 32'h5) begin
         failures++;
         $display("FAIL rd0_rsp got=%b/%h exp=10001/00000005", {rsp_valid, rsp_err, rsp_timeout, bus_if.psel, req_ready}, rsp_rdata);
      end
      tick();
      @(negedge pclk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd0_pulse got=%b exp=0", rsp_valid);
      end
   endtask

   task automatic test_write_wait3();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF;
      bus_if.pready = 1'b0; prdata_val = 32'h1234_5678;
      tick();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0;
      tick();
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus_if.pready = 1'b1;
         @(negedge pclk);
         checks++;
         if ({bus_if.psel, bus_if.penable, bus_if.pwrite, rsp_valid} !== 4'b1110 ||
             bus_if.paddr !== 32'h0000_0010 || bus_if.pwdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr3_access%0d got=%b/%h/%h exp=1110/00000010/deadbeef", c,
                     {bus_if.psel, bus_if.penable, bus_if.pwrite, rsp_valid}, bus_if.paddr, bus_if.pwdata);
         end
         tick();
      end
      bus_if.pready = 1'b0;
      @(negedge pclk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, bus_if.psel} !== 4'b1000 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL wr3_rsp got=%b/%h exp=1000/00000000", {rsp_valid, rsp_err, rsp_timeout, bus_if.psel}, rsp_rdata);
      end
      checks++;
      if (bus_if.paddr !== 32'h0000_0010 || bus_if.pwdata !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL wr3_hold got=%h/%h exp=00000010/deadbeef", bus_if.paddr, bus_if.pwdata);
      end
      tick();
   endtask

   task automatic test_slave_error();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
      bus_if.pready = 1'b1; bus_if.pslverr = 1'b1; prdata_val = 32'hA5A5_0001;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      bus_if.pslverr = 1'b0;
      @(negedge pclk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'hA5A5_0001) begin
         failures++;
         $display("FAIL slverr_rsp got=%b/%h exp=110/a5a50001", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_timeout();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0030;
      bus_if.pready = 1'b0; prdata_val = 32'hBAD0_BAD0;
      tick();
      req_valid = 1'b0;
      tick();
      for (int c = 1; c <= 4; c++) begin
         @(negedge pclk);
         checks++;
         if ({bus_if.psel, bus_if.penable, rsp_valid} !== 3'b110) begin
            failures++;
            $display("FAIL tmo_access%0d got=%b exp=110", c, {bus_if.psel, bus_if.penable, rsp_valid});
         end
         tick();
      end
      @(negedge pclk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_timeout, bus_if.psel, bus_if.penable} !== 5'b11100 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL tmo_rsp got=%b/%h exp=11100/00000000", {rsp_valid, rsp_err, rsp_timeout, bus_if.psel, bus_if.penable}, rsp_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_rd [3];
      logic        done;
      exp_rd[0] = 32'hF0F0_0100; exp_rd[1] = 32'hF0F0_0204; exp_rd[2] = 32'hF0F0_0308;
      b2b_mode = 1'b1; bus_if.pready = 1'b1; bus_if.pslverr = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
      for (int c = 0; c <= 8; c++) begin
         tick();
         if (c == 0) req_addr = 32'h0000_0204;
         if (c == 3) req_addr = 32'h0000_0308;
         if (c == 6) req_valid = 1'b0;
         done = (c == 2) || (c == 5) || (c == 8);
         @(negedge pclk);
         checks++;
         if ({rsp_valid, req_ready, bus_if.psel} !== {done, done, ~done}) begin
            failures++;
            $display("FAIL b2b_cycle%0d got=%b exp=%b", c, {rsp_valid, req_ready, bus_if.psel}, {done, done, ~done});
         end
         if (done) begin
            checks++;
            if (rsp_rdata !== exp_rd[c/3]) begin
               failures++;
               $display("FAIL b2b_rdata%0d got=%h exp=%h", c/3, rsp_rdata, exp_rd[c/3]);
            end
         end
      end
      b2b_mode = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h1;
      bus_if.pready = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      @(negedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      checks++;
      if ({bus_if.psel, bus_if.penable, req_ready} !== 3'b001) begin
         failures++;
         $display("FAIL rst_mid_drop got=%b exp=001", {bus_if.psel, bus_if.penable, req_ready});
      end
      tick();
      presetn = 1'b1;
      bus_if.pready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge pclk);
         checks++;
         if ({rsp_valid, bus_if.psel, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL rst_mid_idle%0d got=%b exp=001", c, {rsp_valid, bus_if.psel, req_ready});
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait3();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
